// File: rtl/udp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_sched
// Brief    : Decides when to launch UDP frames from the ADC FIFO fill level
//            and sequences start pulse, completion watchdog and gap.
// Revision : 1.0
// ============================================================================
module udp_tx_sched #(
    parameter int DATAWIDTH     = 16,
    parameter int ADC_CHANEL    = 8,
    parameter int FIFO_CNT_W    = 11,
    parameter int FRAME_WORDS   = 64,
    parameter int FLUSH_TIMEOUT = 125000,
    parameter int IFG_CYCLES    = 16,
    parameter int DONE_TIMEOUT  = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush_en,
    input  logic [FIFO_CNT_W-1:0] fifo_rd_count,
    input  logic                  tx_done,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    output logic                  busy,
    output logic [31:0]           frame_cnt,
    output logic                  timeout_err,
    output logic [15:0]           err_cnt
);

    localparam int c_WORD_BYTES  = ADC_CHANEL * DATAWIDTH / 8;
    localparam int c_FRAME_BYTES = FRAME_WORDS * c_WORD_BYTES;
    localparam int c_FT_W        = $clog2(FLUSH_TIMEOUT + 1);
    localparam int c_WD_W        = $clog2(DONE_TIMEOUT + 1);
    localparam int c_GAP_W       = $clog2(IFG_CYCLES + 1);

    localparam logic [FIFO_CNT_W-1:0] c_FRAME_WORDS_CNT = FIFO_CNT_W'(FRAME_WORDS);
    localparam logic [15:0]           c_FRAME_BYTES16   = 16'(c_FRAME_BYTES);
    localparam logic [c_FT_W-1:0]     c_FLUSH_LAST      = c_FT_W'(FLUSH_TIMEOUT - 1);
    localparam logic [c_WD_W-1:0]     c_WD_LAST         = c_WD_W'(DONE_TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0]    c_GAP_LAST        = c_GAP_W'(IFG_CYCLES - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_START     = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;
    localparam logic [1:0] c_GAP       = 2'd3;

    generate
        if (c_FRAME_BYTES > 1472) begin : g_frame_size_check
            $error("udp_tx_sched: FRAME_WORDS*WORD_BYTES exceeds 1472 bytes");
        end
        if (IFG_CYCLES < 1 || DONE_TIMEOUT < 2 || FLUSH_TIMEOUT < 1) begin : g_timing_check
            $error("udp_tx_sched: IFG_CYCLES>=1, DONE_TIMEOUT>=2, FLUSH_TIMEOUT>=1 required");
        end
    endgenerate

    logic [1:0]         r_state;
    logic               r_tx_start_en;
    logic [15:0]        r_tx_byte_num;
    logic               r_busy;
    logic [31:0]        r_frame_cnt;
    logic               r_timeout_err;
    logic [15:0]        r_err_cnt;
    logic [c_FT_W-1:0]  r_flush_tmr;
    logic [c_WD_W-1:0]  r_wd;
    logic [c_GAP_W-1:0] r_gap;

    logic               w_full;
    logic               w_flush_cond;
    logic [15:0]        w_flush_bytes;
    logic [c_WD_W-1:0]  w_wd_next;

    assign w_full        = enable && (fifo_rd_count >= c_FRAME_WORDS_CNT);
    assign w_flush_cond  = enable && flush_en && (fifo_rd_count != '0)
                           && (fifo_rd_count < c_FRAME_WORDS_CNT);
    assign w_flush_bytes = 16'(32'(fifo_rd_count) * 32'(c_WORD_BYTES));
    // Expiry is judged on the incremented value so the error pulse lands
    // DONE_TIMEOUT cycles after the start pulse.
    assign w_wd_next     = r_wd + c_WD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_tx_start_en <= 1'b0;
            r_tx_byte_num <= '0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
            r_err_cnt     <= '0;
            r_flush_tmr   <= '0;
            r_wd          <= '0;
            r_gap         <= '0;
        end else begin
            r_tx_start_en <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_full) begin
                        r_tx_byte_num <= c_FRAME_BYTES16;
                        r_tx_start_en <= 1'b1;
                        r_busy        <= 1'b1;
                        r_flush_tmr   <= '0;
                        r_state       <= c_START;
                    end else if (w_flush_cond) begin
                        if (r_flush_tmr == c_FLUSH_LAST) begin
                            r_tx_byte_num <= w_flush_bytes;
                            r_tx_start_en <= 1'b1;
                            r_busy        <= 1'b1;
                            r_flush_tmr   <= '0;
                            r_state       <= c_START;
                        end else begin
                            r_flush_tmr <= r_flush_tmr + c_FT_W'(1);
                        end
                    end else begin
                        r_flush_tmr <= '0;
                    end
                end
                c_START: begin
                    r_wd    <= '0;
                    r_state <= c_WAIT_DONE;
                end
                c_WAIT_DONE: begin
                    // A completion arriving on the expiry cycle wins over the error.
                    if (tx_done) begin
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                        r_gap       <= '0;
                        r_state     <= c_GAP;
                    end else if (w_wd_next == c_WD_LAST) begin
                        r_timeout_err <= 1'b1;
                        if (r_err_cnt != 16'hFFFF) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        r_gap   <= '0;
                        r_state <= c_GAP;
                    end else begin
                        r_wd <= w_wd_next;
                    end
                end
                c_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_gap <= r_gap + c_GAP_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign tx_start_en = r_tx_start_en;
    assign tx_byte_num = r_tx_byte_num;
    assign busy        = r_busy;
    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx_sched
// Brief    : Directed self-checking bench for udp_tx_sched.
// Revision : 1.0
// ============================================================================
module tb_udp_tx_sched;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flush_en;
    logic [10:0] fifo_rd_count;
    logic        tx_done;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        busy;
    logic [31:0] frame_cnt;
    logic        timeout_err;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    udp_tx_sched #(
        .DATAWIDTH    (16),
        .ADC_CHANEL   (8),
        .FIFO_CNT_W   (11),
        .FRAME_WORDS  (4),
        .FLUSH_TIMEOUT(100),
        .IFG_CYCLES   (16),
        .DONE_TIMEOUT (500)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush_en     (flush_en),
        .fifo_rd_count(fifo_rd_count),
        .tx_done      (tx_done),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .timeout_err  (timeout_err),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while (!tx_start_en && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Called in the START cycle: returns tx_done in the first WAIT_DONE cycle.
    task automatic finish_frame(input string tag);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        int n;
        int starts;
        int t_prev;
        rst_n = 1'b0; enable = 1'b0; flush_en = 1'b0; fifo_rd_count = '0; tx_done = 1'b0;
        repeat (3) tick();
        check("rst_start",   32'(tx_start_en), 32'd0);
        check("rst_bytes",   32'(tx_byte_num), 32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_frames",  frame_cnt,        32'd0);
        check("rst_tmo",     32'(timeout_err), 32'd0);
        check("rst_errs",    32'(err_cnt),     32'd0);
        rst_n = 1'b1;
        tick();

        // Full frame, tx_done 200 cycles after the start pulse
        enable = 1'b1; fifo_rd_count = 11'd4;
        tick();
        check("full_start", 32'(tx_start_en), 32'd1);
        check("full_bytes", 32'(tx_byte_num), 32'd64);
        check("full_busy",  32'(busy),        32'd1);
        fifo_rd_count = 11'd0;
        tick();
        check("full_pulse_width", 32'(tx_start_en), 32'd0);
        repeat (199) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("full_frames", frame_cnt, 32'd1);
        repeat (15) tick();
        check("gap_busy_16", 32'(busy), 32'd1);
        tick();
        check("gap_busy_17", 32'(busy), 32'd0);

        // Stray tx_done while idle
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        check("stray_done", frame_cnt, 32'd1);

        // Flush after 100 cycles of a partial FIFO
        flush_en = 1'b1; fifo_rd_count = 11'd3;
        wait_start(300, n);
        check("flush_delay", 32'(n),           32'd100);
        check("flush_bytes", 32'(tx_byte_num), 32'd48);
        fifo_rd_count = 11'd0;
        finish_frame("flush_idle");
        check("flush_frames", frame_cnt, 32'd2);

        // Flush disabled: nothing launches
        flush_en = 1'b0; fifo_rd_count = 11'd3;
        starts = 0;
        repeat (1000) begin
            tick();
            if (tx_start_en) starts++;
        end
        check("noflush_starts", 32'(starts), 32'd0);
        fifo_rd_count = 11'd0;
        tick();

        // Count reaches a full frame on the flush-expiry cycle
        flush_en = 1'b1; fifo_rd_count = 11'd3;
        repeat (99) tick();
        check("cross_no_early", 32'(tx_start_en), 32'd0);
        fifo_rd_count = 11'd4;
        tick();
        check("cross_start", 32'(tx_start_en), 32'd1);
        check("cross_bytes", 32'(tx_byte_num), 32'd64);
        fifo_rd_count = 11'd0; flush_en = 1'b0;
        finish_frame("cross_idle");
        check("cross_frames", frame_cnt, 32'd3);

        // Watchdog expiry
        fifo_rd_count = 11'd4;
        wait_start(5, n);
        check("wd_start", 32'(tx_start_en), 32'd1);
        fifo_rd_count = 11'd0;
        n = 0;
        while (!timeout_err && n < 600) begin
            tick();
            n++;
        end
        check("wd_delay",  32'(n),        32'd500);
        check("wd_errs",   32'(err_cnt),  32'd1);
        check("wd_frames", frame_cnt,     32'd3);
        tick();
        check("wd_pulse_width", 32'(timeout_err), 32'd0);
        wait_idle("wd_idle");
        fifo_rd_count = 11'd4;
        wait_start(5, n);
        check("wd_next_start", 32'(tx_start_en), 32'd1);
        fifo_rd_count = 11'd0;
        finish_frame("wd_next_idle");
        check("wd_next_frames", frame_cnt, 32'd4);

        // Back-to-back frames with count held at 10; enable drops on the last
        fifo_rd_count = 11'd10;
        wait_start(5, n);
        t_prev = cyc;
        for (int i = 0; i < 4; i++) begin
            check("b2b_start", 32'(tx_start_en), 32'd1);
            check("b2b_bytes", 32'(tx_byte_num), 32'd64);
            if (i == 3) enable = 1'b0;
            repeat (50) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("b2b_frames", frame_cnt, 32'(5 + i));
            if (i < 3) begin
                wait_start(100, n);
                check("b2b_spacing", 32'(cyc - t_prev), 32'd68);
                t_prev = cyc;
            end
        end
        starts = 0;
        repeat (200) begin
            tick();
            if (tx_start_en) starts++;
        end
        check("disable_starts", 32'(starts), 32'd0);
        check("disable_busy",   32'(busy),   32'd0);

        // Asynchronous reset during WAIT_DONE
        enable = 1'b1; fifo_rd_count = 11'd4;
        wait_start(5, n);
        fifo_rd_count = 11'd0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy),        32'd0);
        check("arst_bytes",  32'(tx_byte_num), 32'd0);
        check("arst_frames", frame_cnt,        32'd0);
        check("arst_errs",   32'(err_cnt),     32'd0);
        check("arst_start",  32'(tx_start_en), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Frame scheduler that sits between the ADC sample FIFO and the UDP transmit engine.
- Watches the FIFO read-side word count and decides when to launch a UDP frame and how many payload bytes it carries.
- Launches a full frame at a watermark, or a partial "flush" frame after an idle timeout.
- Sequences each frame through start pulse, completion wait (with watchdog) and inter-frame gap.

Parameters:
- DATAWIDTH, 16, bits per ADC channel sample.
- ADC_CHANEL, 8, channels per FIFO word; WORD_BYTES = ADC_CHANEL*DATAWIDTH/8 (16 at defaults).
- FIFO_CNT_W, 11, width of the FIFO word-count input.
- FRAME_WORDS, 64, FIFO words per full frame. FRAME_WORDS*WORD_BYTES must be ≤1472; elaboration error otherwise.
- FLUSH_TIMEOUT, 125000, clk cycles of non-full, non-empty FIFO before a partial frame is sent.
- IFG_CYCLES, 16, idle cycles after each frame before the next may start (≥1).
- DONE_TIMEOUT, 65535, max cycles to wait for tx_done before abandoning the wait.

Ports:
- clk  in  1  system clock (GMII tx clock domain)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable (level)
- flush_en  in  1  allow timeout-driven partial frames
- fifo_rd_count  in  FIFO_CNT_W  words currently readable in ADC FIFO
- tx_done  in  1  one-cycle frame-complete pulse from UDP transmitter
- tx_start_en  out  1  one-cycle start pulse to UDP transmitter
- tx_byte_num  out  16  payload byte count of current/last frame
- busy  out  1  high from start pulse through end of gap
- frame_cnt  out  32  frames completed (wraps 2^32-1 → 0)
- timeout_err  out  1  one-cycle pulse when done watchdog expires
- err_cnt  out  16  watchdog expirations (saturates at 16'hFFFF)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n. Reset forces state IDLE, all counters 0 and every output 0 (tx_start_en, tx_byte_num, busy, frame_cnt, timeout_err, err_cnt). Reset mid-frame abandons the frame immediately with no pulses.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE, full-frame check:
  - If enable=1 and fifo_rd_count ≥ FRAME_WORDS, latch tx_byte_num = FRAME_WORDS*WORD_BYTES and go START.
  - Full-frame check has priority over flush in the same cycle.
- IDLE, flush timer:
  - Increments while enable=1, flush_en=1 and 0 < fifo_rd_count < FRAME_WORDS.
  - Clears whenever that condition is false or a frame starts.
  - When the timer = FLUSH_TIMEOUT-1 and the condition still holds, latch tx_byte_num = fifo_rd_count*WORD_BYTES (16-bit truncation) and go START.
  - Count sampled that cycle is used; later FIFO growth is not added.
- START: tx_start_en=1 for exactly this cycle; busy=1; watchdog cleared; next state WAIT_DONE unconditionally.
- WAIT_DONE:
  - tx_done=1 → frame_cnt+1, go GAP.
  - Else watchdog+1; watchdog = DONE_TIMEOUT-1 → timeout_err=1 for one cycle, err_cnt+1 (saturating), go GAP.
  - tx_done in the same cycle as expiry counts as done; no error.
- GAP: counts IFG_CYCLES cycles, then IDLE with busy=0 on entry to IDLE. The earliest next START is IFG_CYCLES+1 cycles after leaving WAIT_DONE.
- tx_byte_num: stable from the START cycle until the next START; never changes while busy.
- Stray tx_done (IDLE, START or GAP): ignored, no counter change.
- enable deasserted mid-frame: current frame completes normally (START/WAIT_DONE/GAP); no new frame is launched while enable=0. enable rising does not itself start a frame.
- tx_start_en minimum spacing is ≥3 cycles, so the transmitter's rising-edge detector always sees distinct edges.

Test Plan:
- Bench params: FRAME_WORDS=4, WORD_BYTES=16, FLUSH_TIMEOUT=100, IFG_CYCLES=16, DONE_TIMEOUT=500.
- Full frame: rst_n low then high, enable=1, fifo_rd_count=4 → one tx_start_en pulse next cycle with tx_byte_num=64. Return tx_done 200 cycles later → frame_cnt=1; busy low exactly 17 cycles after tx_done.
- Flush: enable=1, flush_en=1, fifo_rd_count=3 held → start pulse after 100 cycles with tx_byte_num=48. Same with flush_en=0 → no start for 1000 cycles.
- Watchdog: start a frame, never assert tx_done → timeout_err single pulse 500 cycles after the START cycle, err_cnt=1, frame_cnt=0, next frame allowed after gap.
- Back-to-back: fifo_rd_count held at 10, tx_done returned 50 cycles after each start → consecutive starts exactly 50+1+16+1 cycles apart, tx_byte_num=64 each, frame_cnt increments per frame.
- Boundaries:
  - enable dropped during WAIT_DONE → frame completes, no further starts.
  - Stray tx_done in IDLE → frame_cnt unchanged.
  - rst_n pulsed low in WAIT_DONE → all outputs 0 asynchronously.
  - Count crossing 4 on the flush-expiry cycle → full 64-byte frame.
